// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: per-register write scoreboard, stall/bubble and
// EXE->ID forward generation, plus a start-up / drain / halt sequencing FSM.
module pipe_hazard_ctrl #(
  parameter int ASIZE  = 5,
  parameter int WB_LAT = 1,
  parameter int CNTW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wen,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             flush,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             busy,
  output logic [1:0]       state,
  output logic [15:0]      stall_cnt
);

  localparam int NREG = 1 << ASIZE;
  localparam logic [CNTW-1:0] LAT = CNTW'(WB_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [CNTW-1:0] cnt [NREG];
  logic [CNTW-1:0] cnt_a, cnt_b;
  logic            pend_a, pend_b, hazard_a, hazard_b, fwdok_a, fwdok_b;
  logic            hazard, run_ok, issue, stall, set_en, sb_empty;

  assign cnt_a    = cnt[id_rs];
  assign cnt_b    = cnt[id_rt];
  assign pend_a   = id_rs_used && (id_rs != '0) && (cnt_a != '0);
  assign pend_b   = id_rt_used && (id_rt != '0) && (cnt_b != '0);
  assign hazard_a = pend_a && (cnt_a > CNTW'(1));
  assign hazard_b = pend_b && (cnt_b > CNTW'(1));
  assign fwdok_a  = pend_a && (cnt_a == CNTW'(1));
  assign fwdok_b  = pend_b && (cnt_b == CNTW'(1));
  assign hazard   = hazard_a | hazard_b;

  assign run_ok = (cur_state == RUN) && !flush && !halt;
  assign issue  = run_ok && id_valid && !hazard;
  assign stall  = run_ok && id_valid && hazard;
  assign set_en = issue && id_wen && (id_waddr != '0);

  assign fwd_a = fwdok_a && issue;
  assign fwd_b = fwdok_b && issue;
  assign busy  = (cur_state != RUN);
  assign state = cur_state;

  always_comb begin
    sb_empty = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) sb_empty = 1'b0;
    end
  end

  // A new write sets the full latency; this wins over the per-edge decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (set_en && (id_waddr == ASIZE'(r)))
          cnt[r] <= LAT;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    case (cur_state)
      IDLE: begin
        ifid_flush = 1'b1;
        nxt_state  = RUN;
      end
      RUN: begin
        if (flush || halt) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          nxt_state  = DRAIN;
        end else if (!stall) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_bubble = !id_valid;
        end
      end
      DRAIN: begin
        if (sb_empty) nxt_state = halt ? HALTED : RUN;
      end
      HALTED: begin
        if (!halt) nxt_state = RUN;
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (WB_LAT 1, 3, 7) share one stimulus
// stream and are compared every cycle against a write-timestamp reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_rs_used, id_rt_used, id_wen, flush, halt;
  logic [4:0] id_rs, id_rt, id_waddr;

  logic        pc_v [3];
  logic        en_v [3];
  logic        fl_v [3];
  logic        bub_v [3];
  logic        fa_v [3];
  logic        fb_v [3];
  logic        busy_v [3];
  logic [1:0]  st_v [3];
  logic [15:0] sc_v [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .ASIZE (5),
      .WB_LAT(g == 0 ? 1 : (g == 1 ? 3 : 7)),
      .CNTW  (3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rs_used (id_rs_used),
      .id_rt      (id_rt),
      .id_rt_used (id_rt_used),
      .id_wen     (id_wen),
      .id_waddr   (id_waddr),
      .flush      (flush),
      .halt       (halt),
      .pc_en      (pc_v[g]),
      .ifid_en    (en_v[g]),
      .ifid_flush (fl_v[g]),
      .idex_bubble(bub_v[g]),
      .fwd_a      (fa_v[g]),
      .fwd_b      (fb_v[g]),
      .busy       (busy_v[g]),
      .state      (st_v[g]),
      .stall_cnt  (sc_v[g])
    );
  end

  int    n_cmp = 0;
  int    n_err = 0;
  string tag_s [3][9];

  // Model: remember the cycle each register's write issued; remaining latency follows.
  longint issue_cyc [3][32];
  longint cyc = 0;
  int     mstate [3];
  int     msc [3];

  typedef struct {
    bit pc, en, fl, bub, fa, fb, busy, issue, stall;
    int st;
  } exp_t;

  function automatic int latOf(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
  endfunction

  function automatic int remOf(int k, logic [4:0] r);
    longint d;
    if (r == 5'd0) return 0;
    d = longint'(latOf(k)) - (cyc - issue_cyc[k][r] - 1);
    return (d > 0) ? int'(d) : 0;
  endfunction

  function automatic exp_t modelOut(int k);
    exp_t e;
    int   ra, rb;
    bit   ha, hb, oka, okb, run_ok;
    ra = id_rs_used ? remOf(k, id_rs) : 0;
    rb = id_rt_used ? remOf(k, id_rt) : 0;
    ha = (ra > 1);
    hb = (rb > 1);
    oka = (ra == 1);
    okb = (rb == 1);
    run_ok = (mstate[k] == 1) && !flush && !halt;
    e.issue = run_ok && id_valid && !(ha || hb);
    e.stall = run_ok && id_valid && (ha || hb);
    e.fa = oka && e.issue;
    e.fb = okb && e.issue;
    e.st = mstate[k];
    e.busy = (mstate[k] != 1);
    e.pc = 1'b0;
    e.en = 1'b0;
    e.fl = 1'b0;
    e.bub = 1'b1;
    if (mstate[k] == 0) begin
      e.fl = 1'b1;
    end else if (mstate[k] == 1) begin
      if (flush || halt) begin
        e.en = 1'b1;
        e.fl = 1'b1;
      end else if (!e.stall) begin
        e.pc = 1'b1;
        e.en = 1'b1;
        e.bub = !id_valid;
      end
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mstate[k] = 0;
      msc[k] = 0;
      for (int r = 0; r < 32; r++) issue_cyc[k][r] = -1000000;
    end
  endtask

  task automatic modelEdge();
    exp_t e;
    bit   sbe;
    if (!rst) begin
      modelReset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        e = modelOut(k);
        sbe = 1'b1;
        for (int r = 1; r < 32; r++) if (remOf(k, 5'(r)) != 0) sbe = 1'b0;
        if (e.issue && id_wen && id_waddr != 5'd0) issue_cyc[k][id_waddr] = cyc;
        if (e.stall && msc[k] < 65535) msc[k]++;
        case (mstate[k])
          0: mstate[k] = 1;
          1: if (flush || halt) mstate[k] = 2;
          2: if (sbe) mstate[k] = halt ? 3 : 1;
          default: if (!halt) mstate[k] = 1;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic checkAll();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e = modelOut(k);
      checkOutput(tag_s[k][0], 32'(pc_v[k]), 32'(e.pc));
      checkOutput(tag_s[k][1], 32'(en_v[k]), 32'(e.en));
      checkOutput(tag_s[k][2], 32'(fl_v[k]), 32'(e.fl));
      checkOutput(tag_s[k][3], 32'(bub_v[k]), 32'(e.bub));
      checkOutput(tag_s[k][4], 32'(fa_v[k]), 32'(e.fa));
      checkOutput(tag_s[k][5], 32'(fb_v[k]), 32'(e.fb));
      checkOutput(tag_s[k][6], 32'(busy_v[k]), 32'(e.busy));
      checkOutput(tag_s[k][7], 32'(st_v[k]), 32'(e.st));
      checkOutput(tag_s[k][8], 32'(sc_v[k]), 32'(msc[k]));
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [4:0] rs, input bit rsu,
                               input logic [4:0] rt, input bit rtu, input bit wen,
                               input logic [4:0] wa, input bit fl, input bit ht,
                               input int n = 1);
    id_valid = v;
    id_rs = rs;
    id_rs_used = rsu;
    id_rt = rt;
    id_rt_used = rtu;
    id_wen = wen;
    id_waddr = wa;
    flush = fl;
    halt = ht;
    repeat (n) begin
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
    end
  endtask

  // Outputs must fall to IDLE values the moment reset asserts, without a clock edge.
  task automatic checkResetNow();
    for (int k = 0; k < 3; k++) begin
      checkOutput({"rst.", tag_s[k][0]}, 32'(pc_v[k]), 32'd0);
      checkOutput({"rst.", tag_s[k][1]}, 32'(en_v[k]), 32'd0);
      checkOutput({"rst.", tag_s[k][2]}, 32'(fl_v[k]), 32'd1);
      checkOutput({"rst.", tag_s[k][3]}, 32'(bub_v[k]), 32'd1);
      checkOutput({"rst.", tag_s[k][4]}, 32'(fa_v[k]), 32'd0);
      checkOutput({"rst.", tag_s[k][5]}, 32'(fb_v[k]), 32'd0);
      checkOutput({"rst.", tag_s[k][6]}, 32'(busy_v[k]), 32'd1);
      checkOutput({"rst.", tag_s[k][7]}, 32'(st_v[k]), 32'd0);
      checkOutput({"rst.", tag_s[k][8]}, 32'(sc_v[k]), 32'd0);
    end
  endtask

  initial begin
    bit rh;
    for (int k = 0; k < 3; k++) begin
      tag_s[k][0] = $sformatf("L%0d.pc_en", latOf(k));
      tag_s[k][1] = $sformatf("L%0d.ifid_en", latOf(k));
      tag_s[k][2] = $sformatf("L%0d.ifid_flush", latOf(k));
      tag_s[k][3] = $sformatf("L%0d.idex_bubble", latOf(k));
      tag_s[k][4] = $sformatf("L%0d.fwd_a", latOf(k));
      tag_s[k][5] = $sformatf("L%0d.fwd_b", latOf(k));
      tag_s[k][6] = $sformatf("L%0d.busy", latOf(k));
      tag_s[k][7] = $sformatf("L%0d.state", latOf(k));
      tag_s[k][8] = $sformatf("L%0d.stall_cnt", latOf(k));
    end
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    // write r3, then read it on source A
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 8);
    // write r5, then read it on source B
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    applyStimulus(1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 8);
    // r0 is never tracked
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 3);
    // write r7 then flush, drain back to RUN
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    applyStimulus(1, 5'd7, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    // halt with empty scoreboard, then release
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // flush and halt together while a write is pending
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd4, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

    // async reset while r9 is pending, stall on r9 in flight
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    applyStimulus(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    checkResetNow();
    modelReset();
    applyStimulus(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 5'd9, 1, 5'd9, 1, 0, 0, 0, 0, 4);

    rh = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rh = !rh;
      applyStimulus($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 7)), $urandom_range(0, 15) == 0, rh);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 12);

    // back-to-back read-modify-write of r5 keeps stalling until the counter saturates
    applyStimulus(1, 5'd5, 1, 0, 0, 1, 5'd5, 0, 0, 77000);
    checkOutput("L7.stall_sat", 32'(sc_v[2]), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
